// File: rtl/data_mem_responder.sv
// Data-memory responder: word-addressed RAM behind an IDLE/WAIT/ACCESS FSM with
// programmable wait states, a one-cycle ready pulse and an error flag. Define DMEM_ZERO_WAIT_EN to bypass WAIT.
module data_mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h10010000,
    parameter int          DEPTH_LOG2  = 7,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] dAddress,
    input  logic [31:0] dWriteData,
    output logic [31:0] dReadData,
    output logic        mem_ready,
    output logic        mem_err
);

    localparam int          DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];
    localparam logic [3:0]  WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
`ifdef DMEM_ZERO_WAIT_EN
    localparam bit SKIP_WAIT = 1'b1;
`else
    localparam bit SKIP_WAIT = (WAIT_STATES == 0);
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic        rd_reg, rd_next;
    logic        wr_reg, wr_next;
    logic [31:0] rdata_next;
    logic        ready_next;
    logic        err_next;

    logic [31:0] ram [DEPTH];

    // BASE_ADDR is word aligned, so the word offset is exactly off[31:2].
    logic [29:0]           off_word;
    logic                  in_range;
    logic                  access_err;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  ram_we;

    always_comb begin
        off_word   = addr_reg[31:2] - BASE_WORD;
        in_range   = (addr_reg >= BASE_ADDR) && ({2'b00, off_word} < 32'(DEPTH));
        access_err = (addr_reg[1:0] != 2'b00) || !in_range || (rd_reg && wr_reg);
        idx        = off_word[DEPTH_LOG2-1:0];
        ram_we     = (state_reg == ST_ACCESS) && wr_reg && !access_err;
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        rd_next    = rd_reg;
        wr_next    = wr_reg;
        rdata_next = dReadData;
        ready_next = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (MemRead || MemWrite) begin
                    addr_next  = dAddress;
                    wdata_next = dWriteData;
                    rd_next    = MemRead;
                    wr_next    = MemWrite;
                    if (SKIP_WAIT) begin
                        state_next = ST_ACCESS;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = ST_ACCESS;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_ACCESS: begin
                ready_next = 1'b1;
                err_next   = access_err;
                if (access_err) begin
                    rdata_next = 32'd0;
                end else if (rd_reg) begin
                    rdata_next = ram[idx];
                end
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            addr_reg  <= 32'd0;
            wdata_reg <= 32'd0;
            rd_reg    <= 1'b0;
            wr_reg    <= 1'b0;
            dReadData <= 32'd0;
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            rd_reg    <= rd_next;
            wr_reg    <= wr_next;
            dReadData <= rdata_next;
            mem_ready <= ready_next;
            mem_err   <= err_next;
        end
    end

    // RAM is never cleared; a reset forces IDLE so a pending write can't commit.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[idx] <= wdata_reg;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed table, reset/back-to-back
// sequences and randomized traffic against an address-arithmetic memory model.
module tb_data_mem_responder;

    localparam logic [31:0] BASE = 32'h10010000;
    localparam int WS = 3;
`ifdef DMEM_ZERO_WAIT_EN
    localparam int LAT = 1;
`else
    localparam int LAT = WS + 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] dAddress = 32'd0;
    logic [31:0] dWriteData = 32'd0;
    logic [31:0] dReadData;
    logic        mem_ready;
    logic        mem_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] model_mem [128];
    logic [31:0] model_hold = 32'd0;

    data_mem_responder #(
        .BASE_ADDR(BASE),
        .DEPTH_LOG2(7),
        .WAIT_STATES(WS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .MemRead(MemRead),
        .MemWrite(MemWrite),
        .dAddress(dAddress),
        .dWriteData(dWriteData),
        .dReadData(dReadData),
        .mem_ready(mem_ready),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: decide the outcome from plain address arithmetic.
    task automatic model_step(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                              output logic [31:0] exp_rdata, output bit exp_err);
        longint unsigned aa = longint'(a);
        longint unsigned bb = longint'(BASE);
        bit bad = (aa < bb) || (aa % 4 != 0) || (rd && wr);
        if (!bad && ((aa - bb) / 4 >= 128)) bad = 1'b1;
        if (bad) begin
            model_hold = 32'd0;
            exp_err = 1'b1;
        end else begin
            exp_err = 1'b0;
            if (wr) model_mem[int'((aa - bb) / 4)] = d;
            else model_hold = model_mem[int'((aa - bb) / 4)];
        end
        exp_rdata = model_hold;
    endtask

    // One complete transaction: accept, wait for ready, drop request, confirm single pulse.
    task automatic xact(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rdata, output bit err);
        int lat;
        @(negedge clk);
        MemRead = rd; MemWrite = wr; dAddress = a; dWriteData = d;
        @(posedge clk); #1;
        dAddress = $urandom; dWriteData = $urandom;
        lat = 0;
        while (!mem_ready && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = dReadData;
        err = mem_err;
        MemRead = 1'b0; MemWrite = 1'b0;
        chk("latency", 32'(lat), 32'(LAT));
        @(posedge clk); #1;
        chk("single_pulse", {31'd0, mem_ready}, 32'd0);
        chk("err_idle", {31'd0, mem_err}, 32'd0);
        $display("xact rd=%0b wr=%0b addr=%h data=%h -> rdata=%h err=%0b lat=%0d",
                 rd, wr, a, d, rdata, err, lat);
    endtask

    task automatic run_checked(input string tag, input bit rd, input bit wr,
                               input logic [31:0] a, input logic [31:0] d);
        logic [31:0] got_r, exp_r;
        bit got_e, exp_e;
        model_step(rd, wr, a, d, exp_r, exp_e);
        xact(rd, wr, a, d, got_r, got_e);
        chk({tag, "_err"}, {31'd0, got_e}, {31'd0, exp_e});
        chk({tag, "_rdata"}, got_r, exp_r);
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    initial begin
        vec_t vecs[11];
        logic [31:0] got_r, dummy_r;
        bit got_e, dummy_e;
        int lat;

        vecs[0]  = '{1'b1, 1'b0, 32'h10010000, 32'h0,        32'hA5000000, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 32'h10010008, 32'hDEADBEEF, 32'hA5000000, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h10010008, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 32'h10010006, 32'h55555555, 32'h00000000, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 32'h10010004, 32'h0,        32'hA5000001, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'h10010200, 32'h0,        32'h00000000, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 32'h1000FFFC, 32'h0,        32'h00000000, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 32'h1001000C, 32'h11111111, 32'h00000000, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 32'h1001000C, 32'h0,        32'hA5000003, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 32'h100101FC, 32'hCAFEF00D, 32'hA5000003, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 32'h100101FC, 32'h0,        32'hCAFEF00D, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdata", dReadData, 32'd0);
        chk("reset_ready", {31'd0, mem_ready}, 32'd0);
        chk("reset_err", {31'd0, mem_err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Fill every word with a known pattern
        for (int i = 0; i < 128; i++)
            run_checked("init", 1'b0, 1'b1, BASE + 32'(4 * i), 32'hA5000000 | 32'(i));

        // Directed table
        for (int i = 0; i < 11; i++) begin
            model_step(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, dummy_r, dummy_e);
            xact(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, got_r, got_e);
            chk($sformatf("vec%0d_err", i), {31'd0, got_e}, {31'd0, vecs[i].exp_err});
            chk($sformatf("vec%0d_rdata", i), got_r, vecs[i].exp_rdata);
        end

        // Reset while a write is in flight
        @(negedge clk);
        MemWrite = 1'b1; dAddress = 32'h10010010; dWriteData = 32'h12345678;
        @(posedge clk); #1;
        MemWrite = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("midreset_rdata", dReadData, 32'd0);
        chk("midreset_ready", {31'd0, mem_ready}, 32'd0);
        chk("midreset_err", {31'd0, mem_err}, 32'd0);
        model_hold = 32'd0;
        $display("xact reset during write addr=10010010 data=12345678");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        run_checked("midreset_readback", 1'b1, 1'b0, 32'h10010010, 32'h0);

        // Back-to-back: write held one cycle past ready is accepted again
        @(negedge clk);
        MemWrite = 1'b1; dAddress = 32'h100101FC; dWriteData = 32'h600DF00D;
        @(posedge clk); #1;
        lat = 0;
        while (!mem_ready && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("b2b_lat1", 32'(lat), 32'(LAT));
        chk("b2b_err1", {31'd0, mem_err}, 32'd0);
        @(posedge clk); #1;
        MemWrite = 1'b0;
        chk("b2b_gap", {31'd0, mem_ready}, 32'd0);
        lat = 0;
        while (!mem_ready && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("b2b_lat2", 32'(lat), 32'(LAT));
        chk("b2b_err2", {31'd0, mem_err}, 32'd0);
        @(posedge clk); #1;
        chk("b2b_pulse2", {31'd0, mem_ready}, 32'd0);
        model_step(1'b0, 1'b1, 32'h100101FC, 32'h600DF00D, dummy_r, dummy_e);
        $display("xact back-to-back write addr=100101FC data=600DF00D");
        run_checked("b2b_read", 1'b1, 1'b0, 32'h100101FC, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            int kind = $urandom_range(0, 9);
            int op = $urandom_range(0, 9);
            logic [31:0] a;
            bit rd, wr;
            if (kind <= 6)      a = BASE + 32'(4 * $urandom_range(0, 127));
            else if (kind == 7) a = BASE + 32'(4 * $urandom_range(0, 127)) + 32'($urandom_range(1, 3));
            else if (kind == 8) a = BASE + 32'd512 + 32'(4 * $urandom_range(0, 1000));
            else                a = BASE - 32'(4 * $urandom_range(1, 1000));
            rd = (op <= 4) || (op == 9);
            wr = (op >= 5);
            run_checked("rand", rd, wr, a, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
